// File: rtl/ads1115_target.sv
// rtl/ads1115_target.sv - I2C target emulating the ADS1115 register map and ALERT/RDY pin
module ads1115_target #(
  parameter logic [6:0] ADDR         = 7'h48,
  parameter int         ALERT_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda_oe,
  input  logic [15:0] i_sample,
  input  logic        i_sample_valid,
  output logic        o_alert,
  output logic [15:0] o_config,
  output logic        o_busy
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_MACK, S_WAIT_STOP
  } state_t;

  localparam int CW = $clog2(ALERT_CYCLES + 1);

  state_t        state, state_n;
  logic [1:0]    scl_sync, sda_sync;
  logic          scl_q, sda_q;
  logic          scl, sda, scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;
  logic [7:0]    byte_in, wr_msb, tx_byte;
  logic          tx_bit, last_bit, addr_match, ready;
  logic          rw, wr_lsb, rd_lsb, ack_on, ack_on_n, sda_oe, sda_oe_n, busy;
  logic [1:0]    ptr;
  logic [15:0]   conv, cfg, lo, hi, snap, reg_at_ptr;
  logic [CW-1:0] alert_cnt;

  // Synchronizers idle high so reset release never fakes a bus edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], i_scl};
      sda_sync <= {sda_sync[0], i_sda};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl        = scl_sync[1];
  assign sda        = sda_sync[1];
  assign scl_rise   = scl & ~scl_q;
  assign scl_fall   = ~scl & scl_q;
  assign start_det  = scl & scl_q & sda_q & ~sda;
  assign stop_det   = scl & scl_q & ~sda_q & sda;
  assign byte_in    = {shreg, sda};
  assign last_bit   = (bit_cnt == 3'd7);
  assign addr_match = (byte_in[7:1] == ADDR);
  assign tx_byte    = rd_lsb ? snap[7:0] : snap[15:8];
  assign tx_bit     = tx_byte[3'd7 - bit_cnt];
  assign ready      = hi[15] & ~lo[15];

  always_comb begin
    case (ptr)
      2'd0:    reg_at_ptr = conv;
      2'd1:    reg_at_ptr = cfg;
      2'd2:    reg_at_ptr = lo;
      default: reg_at_ptr = hi;
    endcase
  end

  always_comb begin
    state_n  = state;
    sda_oe_n = sda_oe;
    ack_on_n = ack_on;
    if (start_det) begin
      state_n  = S_ADDR;
      sda_oe_n = 1'b0;
      ack_on_n = 1'b0;
    end else if (stop_det) begin
      state_n  = S_IDLE;
      sda_oe_n = 1'b0;
      ack_on_n = 1'b0;
    end else begin
      case (state)
        S_ADDR: if (scl_rise && last_bit) state_n = addr_match ? S_ADDR_ACK : S_WAIT_STOP;
        S_PTR: if (scl_rise && last_bit) state_n = S_PTR_ACK;
        S_WR_BYTE: if (scl_rise && last_bit) state_n = S_WR_ACK;
        // First SCL fall after the byte pulls SDA, the next one ends the ACK clock.
        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_oe_n = 1'b1;
              ack_on_n = 1'b1;
            end else begin
              ack_on_n = 1'b0;
              sda_oe_n = 1'b0;
              if (state == S_ADDR_ACK) begin
                if (rw) begin
                  state_n  = S_RD_BYTE;
                  sda_oe_n = ~tx_bit;
                end else begin
                  state_n = S_PTR;
                end
              end else begin
                state_n = S_WR_BYTE;
              end
            end
          end
        end
        S_RD_BYTE: begin
          if (scl_fall) sda_oe_n = ~tx_bit;
          else if (scl_rise && last_bit) state_n = S_RD_MACK;
        end
        S_RD_MACK: begin
          if (scl_fall) sda_oe_n = 1'b0;
          else if (scl_rise) state_n = sda ? S_WAIT_STOP : S_RD_BYTE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      sda_oe  <= 1'b0;
      ack_on  <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      wr_msb  <= '0;
      rw      <= 1'b0;
      wr_lsb  <= 1'b0;
      rd_lsb  <= 1'b0;
      busy    <= 1'b0;
      ptr     <= '0;
      conv    <= 16'h0000;
      cfg     <= 16'h8583;
      lo      <= 16'h8000;
      hi      <= 16'h7FFF;
      snap    <= '0;
    end else begin
      state  <= state_n;
      sda_oe <= sda_oe_n;
      ack_on <= ack_on_n;
      if (i_sample_valid) conv <= i_sample;
      if (start_det) begin
        bit_cnt <= '0;
      end else if (stop_det) begin
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          S_ADDR: begin
            shreg   <= byte_in[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              busy   <= addr_match;
              rw     <= byte_in[0];
              rd_lsb <= 1'b0;
              snap   <= reg_at_ptr;
            end
          end
          S_PTR: begin
            shreg   <= byte_in[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              ptr    <= byte_in[1:0];
              wr_lsb <= 1'b0;
            end
          end
          S_WR_BYTE: begin
            shreg   <= byte_in[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              wr_lsb <= ~wr_lsb;
              if (!wr_lsb) begin
                wr_msb <= byte_in;
              end else begin
                case (ptr)
                  2'd1:    cfg <= {wr_msb, byte_in};
                  2'd2:    lo  <= {wr_msb, byte_in};
                  2'd3:    hi  <= {wr_msb, byte_in};
                  default: ;
                endcase
              end
            end
          end
          S_RD_BYTE: bit_cnt <= bit_cnt + 3'd1;
          S_RD_MACK: begin
            if (sda) begin
              busy <= 1'b0;
            end else begin
              rd_lsb <= ~rd_lsb;
              if (rd_lsb) snap <= reg_at_ptr;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A strobe in ready mode (re)arms the pulse; leaving ready mode releases the pin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alert_cnt <= '0;
    end else if (i_sample_valid && ready) begin
      alert_cnt <= CW'(ALERT_CYCLES);
    end else if (alert_cnt != '0) begin
      alert_cnt <= alert_cnt - CW'(1);
    end
  end

  assign o_alert  = ~(ready && (alert_cnt != '0));
  assign o_sda_oe = sda_oe;
  assign o_config = cfg;
  assign o_busy   = busy;
endmodule
